// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, miss absorption and redirect handling.
// Optional exception redirect is compiled in when FETCH_EXC_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_1000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_2000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EN_REG,
    input  logic        flush,
    input  logic        block_pipe_data_cache,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exc_req,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_ready,
    input  logic [31:0] ic_rdata,
    output logic        block_pipe_instr_cache,
    output logic [31:0] instruction,
    output logic [31:0] PC,
    output logic [31:0] PCNEXT,
    output logic        valid,
    output logic [31:0] EPC
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MISS  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] drain_addr_r, drain_s;
    logic [31:0] instr_s, pc_out_s, pcnext_s, epc_s, redirect_addr_s, ic_addr_s;
    logic        valid_s, adv_en_s, exc_s, redirect_s, ic_req_s, blk_s;
    logic        unused_s;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    assign unused_s = ^{exc_req, branch_target[1:0]};

    // Next-state, next-PC and next IF/ID contents; priority exc > branch > flush > advance > hold.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        drain_s  = drain_addr_r;
        instr_s  = instruction;
        pc_out_s = PC;
        pcnext_s = PCNEXT;
        valid_s  = valid;
        epc_s    = EPC;
        adv_en_s = EN_REG & ~block_pipe_data_cache;
`ifdef FETCH_EXC_EN
        exc_s = exc_req & (state_r != IDLE);
`else
        exc_s = 1'b0;
`endif
        redirect_s      = exc_s | (branch_taken & (state_r != IDLE));
        redirect_addr_s = exc_s ? EXC_VECTOR : word_align(branch_target);

        if (state_r == IDLE) begin
            state_s = FETCH;
        end else if (redirect_s) begin
            pc_s    = redirect_addr_s;
            instr_s = NOP_INSTR;
            valid_s = 1'b0;
            if (exc_s) begin
                epc_s = valid ? PC : pc_r;
            end else begin
                epc_s = EPC;
            end
            // The outstanding miss must still complete before the new address is issued.
            case (state_r)
                MISS:    begin state_s = DRAIN; drain_s = pc_r; end
                DRAIN:   begin state_s = DRAIN; drain_s = drain_addr_r; end
                default: state_s = FETCH;
            endcase
        end else if (flush) begin
            instr_s = NOP_INSTR;
            valid_s = 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (!ic_ready) begin
                        state_s = MISS;
                    end else begin
                        state_s = FETCH;
                    end
                end
                MISS: begin
                    if (ic_ready) begin
                        state_s = FETCH;
                    end else begin
                        state_s = MISS;
                    end
                end
                DRAIN: begin
                    if (ic_ready) begin
                        state_s = FETCH;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                default: state_s = IDLE;
            endcase
            if ((state_r == FETCH || state_r == MISS) && adv_en_s) begin
                if (ic_ready) begin
                    instr_s  = ic_rdata;
                    pc_out_s = pc_r;
                    pcnext_s = pc_r + 32'd4;
                    valid_s  = 1'b1;
                    pc_s     = pc_r + 32'd4;
                end else begin
                    instr_s = NOP_INSTR;
                    valid_s = 1'b0;
                end
            end else begin
                valid_s = valid;
            end
        end

        ic_req_s  = (state_s != IDLE);
        ic_addr_s = (state_s == DRAIN) ? drain_s : pc_s;
        blk_s     = (state_s == MISS) || (state_s == DRAIN);
    end

    // State, PC and registered cache/IF/ID outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r                <= IDLE;
            pc_r                   <= RESET_PC;
            drain_addr_r           <= RESET_PC;
            ic_req                 <= 1'b0;
            ic_addr                <= RESET_PC;
            block_pipe_instr_cache <= 1'b0;
            instruction            <= NOP_INSTR;
            PC                     <= 32'd0;
            PCNEXT                 <= 32'd0;
            valid                  <= 1'b0;
            EPC                    <= 32'd0;
        end else begin
            state_r                <= state_s;
            pc_r                   <= pc_s;
            drain_addr_r           <= drain_s;
            ic_req                 <= ic_req_s;
            ic_addr                <= ic_addr_s;
            block_pipe_instr_cache <= blk_s;
            instruction            <= instr_s;
            PC                     <= pc_out_s;
            PCNEXT                 <= pcnext_s;
            valid                  <= valid_s;
            EPC                    <= epc_s;
        end
    end

endmodule
